// File: rtl/clk_freq_meter_pkg.sv
// Shared constants for the frequency meter: FSM encoding and the default gate
// length, which the clock divider also uses as its toggle constant.
package clk_freq_meter_pkg;

    localparam int unsigned DEFAULT_GATE_CYCLES = 50_000_000;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;

    function automatic logic is_busy(input logic [1:0] st);
        return (st == ST_MEASURE) || (st == ST_DONE);
    endfunction

endpackage

// File: rtl/clk_freq_meter_if.sv
// Control and result bundle between a measurement requester and the meter.
interface clk_freq_meter_if #(
    parameter int CNT_W = 32
);
    logic             start;
    logic             continuous;
    logic             busy;
    logic [CNT_W-1:0] freq_count;
    logic             valid;
    logic             overflow;

    modport master (
        output start, continuous,
        input  busy, freq_count, valid, overflow
    );

    modport slave (
        input  start, continuous,
        output busy, freq_count, valid, overflow
    );
endinterface

// File: rtl/clk_freq_meter_sync_edge_detect.sv
// Multi-flop synchronizer for an asynchronous input followed by a rising-edge
// detector producing a single-cycle pulse in the clk_in domain.
module sync_edge_detect #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic rst,
    input  logic d_async,
    output logic rise_p
);
    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;
    logic                   prev_q;
    logic                   prev_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d_async};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign rise_p = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/clk_freq_meter.sv
// Gated edge counter: counts rising edges of sig_in over GATE_CYCLES clk_in
// cycles and presents the result with a one-cycle valid strobe.
module clk_freq_meter
    import clk_freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = DEFAULT_GATE_CYCLES,
    parameter int          CNT_W       = 32,
    parameter int          GATE_W      = 33,
    parameter int          SYNC_STAGES = 2
) (
    input  logic            clk_in,
    input  logic            rst,
    input  logic            sig_in,
    clk_freq_meter_if.slave bus
);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);

    logic              edge_p;
    logic [1:0]        state_q, state_d;
    logic [GATE_W-1:0] gate_q,  gate_d;
    logic [CNT_W-1:0]  edge_q,  edge_d;
    logic              sat_q,   sat_d;
    logic [CNT_W-1:0]  freq_q,  freq_d;
    logic              ovf_q,   ovf_d;
    logic              valid_q, valid_d;
    logic              busy_q,  busy_d;

    sync_edge_detect #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_in (clk_in),
        .rst    (rst),
        .d_async(sig_in),
        .rise_p (edge_p)
    );

    always_comb begin
        state_d = state_q;
        gate_d  = gate_q;
        edge_d  = edge_q;
        sat_d   = sat_q;
        freq_d  = freq_q;
        ovf_d   = ovf_q;
        valid_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.start || bus.continuous) begin
                    gate_d  = '0;
                    edge_d  = '0;
                    sat_d   = 1'b0;
                    state_d = ST_MEASURE;
                end
            end
            ST_MEASURE: begin
                gate_d = gate_q + 1'b1;
                if (edge_p) begin
                    if (&edge_q) sat_d  = 1'b1;
                    else         edge_d = edge_q + 1'b1;
                end
                // Result is captured on entry to DONE so valid and freq_count
                // are both high during the DONE cycle, including the last edge.
                if (gate_q == GATE_LAST) begin
                    state_d = ST_DONE;
                    freq_d  = edge_d;
                    ovf_d   = sat_d;
                    valid_d = 1'b1;
                end
            end
            ST_DONE: begin
                if (bus.continuous) begin
                    gate_d  = '0;
                    edge_d  = '0;
                    sat_d   = 1'b0;
                    state_d = ST_MEASURE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = is_busy(state_d);
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gate_q  <= '0;
            edge_q  <= '0;
            sat_q   <= 1'b0;
            freq_q  <= '0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gate_q  <= gate_d;
            edge_q  <= edge_d;
            sat_q   <= sat_d;
            freq_q  <= freq_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.busy       = busy_q;
    assign bus.freq_count = freq_q;
    assign bus.valid      = valid_q;
    assign bus.overflow   = ovf_q;

endmodule
